trng_ctrl: RTL

TRNG_CTRL -- requirements
Module: trng_ctrl

---
 rtl/trng_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/trng_ctrl.sv
// TRNG front-end: polls the core, runs a repetition-count health test
// and buffers accepted entropy words in a small FIFO.
module trng_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_WAIT  = 16,
    parameter int RCT_LIMIT  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        trng_cs,
    output logic        trng_we,
    output logic [7:0]  trng_address,
    input  logic [31:0] trng_read_data,
    input  logic        trng_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    input  logic        rd_pop,
    output logic [4:0]  level,
    output logic        health_fail,
    input  logic        fail_clr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_DATA   = 8'h20;

    typedef enum logic [2:0] {
        S_WAIT,
        S_POLL,
        S_FETCH,
        S_CHECK,
        S_HALT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    wait_cnt;
    logic          wait_done;
    logic [31:0]   word_q;
    logic [31:0]   prev_word;
    logic [3:0]    rep_cnt;
    logic [3:0]    rep_nxt;
    logic          warm;
    logic          is_rep;
    logic          trip;
    logic          push;
    logic          pop;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    count;

    assign wait_done = (wait_cnt == 8'(POLL_WAIT - 1));
    assign is_rep    = !warm && (word_q == prev_word);
    assign rep_nxt   = rep_cnt + 4'd1;
    assign trip      = is_rep && (rep_nxt == 4'(RCT_LIMIT));
    assign push      = (state == S_CHECK) && !warm && !is_rep;
    assign pop       = rd_pop && rd_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_WAIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_WAIT:
                if (wait_done && (count < 5'(FIFO_DEPTH)))
                    state_nxt = S_POLL;
            S_POLL:
                if (trng_ready)
                    state_nxt = trng_read_data[0] ? S_FETCH : S_WAIT;
            S_FETCH:
                if (trng_ready) state_nxt = S_CHECK;
            S_CHECK:
                state_nxt = trip ? S_HALT : S_WAIT;
            S_HALT:
                if (fail_clr) state_nxt = S_WAIT;
            default:
                state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        trng_cs      = 1'b0;
        trng_address = 8'h00;
        unique case (state)
            S_POLL: begin
                trng_cs      = 1'b1;
                trng_address = ADDR_STATUS;
            end
            S_FETCH: begin
                trng_cs      = 1'b1;
                trng_address = ADDR_DATA;
            end
            default: ;
        endcase
    end

    assign trng_we = 1'b0;

    // Wait counter runs only in WAIT and parks at expiry while the FIFO is full
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            word_q      <= '0;
            prev_word   <= '0;
            rep_cnt     <= '0;
            warm        <= 1'b1;
            health_fail <= 1'b0;
        end else begin
            if (state != S_WAIT)  wait_cnt <= '0;
            else if (!wait_done)  wait_cnt <= wait_cnt + 8'd1;

            if (state == S_FETCH && trng_ready)
                word_q <= trng_read_data;

            if (fail_clr) begin
                rep_cnt <= '0;
                warm    <= 1'b1;
            end else if (state == S_CHECK) begin
                if (warm) begin
                    prev_word <= word_q;
                    rep_cnt   <= 4'd1;
                    warm      <= 1'b0;
                end else if (is_rep) begin
                    rep_cnt <= rep_nxt;
                end else begin
                    prev_word <= word_q;
                    rep_cnt   <= 4'd1;
                end
            end

            if (state == S_HALT && fail_clr)
                health_fail <= 1'b0;
            else if (state == S_CHECK && trip)
                health_fail <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word_q;
    end

    assign rd_valid = (count != 5'd0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 32'h0;
    assign level    = count;

endmodule
